// File: rtl/golf_pkg.sv
// golf_pkg: shared state encoding, screen geometry and hole defaults for the golf game.
// Also provides in_window(), a square capture test on Q.5 coordinates.
package golf_pkg;

    typedef enum logic [1:0] {AIM, CHARGE, ROLL, SUNK} state_t;

    localparam int SCREEN_W  = 1280;
    localparam int SCREEN_H  = 720;
    localparam int FRAC_BITS = 5;

    // Hole placement is shared with the map renderer so the sprite and the
    // capture window always agree.
    localparam int HOLE_X_DEF = 1100;
    localparam int HOLE_Y_DEF = 360;
    localparam int HOLE_R_DEF = 4;

    // True when the pixel part of v lies within r pixels of centre.
    // The bound is checked on the full fixed-point value: pixel <= c+r is
    // the same as v < (c+r+1)<<FRAC_BITS.
    function automatic logic in_window(input logic signed [17:0] v, input int centre, input int r);
        return int'(v) >= ((centre - r) << FRAC_BITS) && int'(v) < ((centre + r + 1) << FRAC_BITS);
    endfunction

endpackage

// File: rtl/cos_sin_lookup.sv
// cos_sin_lookup: registered sine/cosine magnitude and sign for an angle in degrees.
// Ports:
//   pixel_clk_in         clock
//   rst_in               asynchronous active-high reset
//   angle[8:0]           angle in degrees, 0..359
//   cos_abs/sin_abs[8:0] |cos|, |sin| in Q8 (256 = 1.0), one cycle after angle
//   cos_sign/sin_sign    1 = negative
module cos_sin_lookup (
    input  logic       pixel_clk_in,
    input  logic       rst_in,
    input  logic [8:0] angle,
    output logic [8:0] cos_abs,
    output logic [8:0] sin_abs,
    output logic       cos_sign,
    output logic       sin_sign
);

    // round(256 * sin(d)) for d = 0..90
    localparam logic [8:0] SIN_Q8 [0:90] = '{
        9'd0,   9'd4,   9'd9,   9'd13,  9'd18,  9'd22,  9'd27,  9'd31,  9'd36,  9'd40,
        9'd44,  9'd49,  9'd53,  9'd58,  9'd62,  9'd66,  9'd71,  9'd75,  9'd79,  9'd83,
        9'd88,  9'd92,  9'd96,  9'd100, 9'd104, 9'd108, 9'd112, 9'd116, 9'd120, 9'd124,
        9'd128, 9'd132, 9'd136, 9'd139, 9'd143, 9'd147, 9'd150, 9'd154, 9'd158, 9'd161,
        9'd165, 9'd168, 9'd171, 9'd175, 9'd178, 9'd181, 9'd184, 9'd187, 9'd190, 9'd193,
        9'd196, 9'd199, 9'd202, 9'd204, 9'd207, 9'd210, 9'd212, 9'd215, 9'd217, 9'd219,
        9'd222, 9'd224, 9'd226, 9'd228, 9'd230, 9'd232, 9'd234, 9'd236, 9'd237, 9'd239,
        9'd241, 9'd242, 9'd243, 9'd245, 9'd246, 9'd247, 9'd248, 9'd249, 9'd250, 9'd251,
        9'd252, 9'd253, 9'd254, 9'd254, 9'd255, 9'd255, 9'd255, 9'd256, 9'd256, 9'd256,
        9'd256
    };

    // {sign, |sin a|}: fold the lower half onto the upper, then mirror about 90.
    function automatic logic [9:0] sin_of(input logic [8:0] a);
        logic [8:0] h;
        h = a >= 9'd180 ? a - 9'd180 : a;
        return {a >= 9'd180, SIN_Q8[7'(h <= 9'd90 ? h : 9'd180 - h)]};
    endfunction

    // cos(a) = sin(a + 90)
    logic [8:0] cos_arg;
    assign cos_arg = angle >= 9'd270 ? angle - 9'd270 : angle + 9'd90;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            {sin_sign, sin_abs} <= '0;
            {cos_sign, cos_abs} <= '0;
        end else begin
            {sin_sign, sin_abs} <= sin_of(angle);
            {cos_sign, cos_abs} <= sin_of(cos_arg);
        end
    end

endmodule

// File: rtl/golf_ball_ctrl.sv
// golf_ball_ctrl: aim/charge/shoot controller and per-frame ball physics for the golf game.
// Ports:
//   pixel_clk_in, rst_in         clock, asynchronous active-high reset
//   frame_tick                   one-cycle pulse per frame (vertical blank)
//   btn_left/btn_right/btn_shoot debounced button levels
//   ballx, bally                 ball position, Q.5 pixels (registered)
//   angle                        aim angle in degrees 0..359 (registered)
//   power                        current charge
//   rolling, sunk                ball in motion / ball holed
//   strokes                      shots taken this hole, saturating at 255
module golf_ball_ctrl
    import golf_pkg::*;
#(
    parameter int START_X     = 160,
    parameter int START_Y     = 360,
    parameter int HOLE_X      = HOLE_X_DEF,
    parameter int HOLE_Y      = HOLE_Y_DEF,
    parameter int HOLE_R      = HOLE_R_DEF,
    parameter int SINK_SPEED  = 96,
    parameter int MAX_POWER   = 63,
    parameter int POWER_SCALE = 4,
    parameter int FRICTION    = 1,
    parameter int X_MIN       = 4,
    parameter int X_MAX       = SCREEN_W - 5,
    parameter int Y_MIN       = 4,
    parameter int Y_MAX       = SCREEN_H - 5
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_shoot,
    output logic [15:0] ballx,
    output logic [15:0] bally,
    output logic [15:0] angle,
    output logic [5:0]  power,
    output logic        rolling,
    output logic        sunk,
    output logic [7:0]  strokes
);

    localparam int X_LO = X_MIN << FRAC_BITS;
    localparam int X_HI = X_MAX << FRAC_BITS;
    localparam int Y_LO = Y_MIN << FRAC_BITS;
    localparam int Y_HI = Y_MAX << FRAC_BITS;

    state_t      state, state_n;
    logic [15:0] ballx_n, bally_n, angle_n;
    logic [5:0]  power_n;
    logic [7:0]  strokes_n;
    logic [9:0]  speed, speed_n, speed_dec;
    logic [8:0]  cos_abs, sin_abs, cos_lat, sin_lat, cos_lat_n, sin_lat_n;
    logic        cos_sign, sin_sign, x_neg, y_neg, x_neg_n, y_neg_n, shoot_q;

    cos_sin_lookup u_trig (
        .pixel_clk_in(pixel_clk_in),
        .rst_in      (rst_in),
        .angle       (angle[8:0]),
        .cos_abs     (cos_abs),
        .sin_abs     (sin_abs),
        .cos_sign    (cos_sign),
        .sin_sign    (sin_sign)
    );

    // One motion step, evaluated every cycle and committed only on a ROLL tick.
    logic [18:0]        dx_prod, dy_prod;
    logic signed [17:0] x_cur, y_cur, dx, dy, x_step, y_step, x_clamp, y_clamp;
    logic               x_lo, x_hi, y_lo, y_hi, sink_ok;

    assign dx_prod = {9'd0, speed} * {10'd0, cos_lat};
    assign dy_prod = {9'd0, speed} * {10'd0, sin_lat};
    assign dx      = 18'(dx_prod >> 8);
    assign dy      = 18'(dy_prod >> 8);
    assign x_cur   = $signed({2'b00, ballx});
    assign y_cur   = $signed({2'b00, bally});
    assign x_step  = x_neg ? x_cur - dx : x_cur + dx;
    // screen y grows downward, so a positive sine moves the ball up
    assign y_step  = y_neg ? y_cur + dy : y_cur - dy;
    assign x_lo    = int'(x_step) < X_LO;
    assign x_hi    = int'(x_step) > X_HI;
    assign y_lo    = int'(y_step) < Y_LO;
    assign y_hi    = int'(y_step) > Y_HI;
    assign x_clamp = x_lo ? 18'(X_LO) : x_hi ? 18'(X_HI) : x_step;
    assign y_clamp = y_lo ? 18'(Y_LO) : y_hi ? 18'(Y_HI) : y_step;
    assign speed_dec = speed > 10'(FRICTION) ? speed - 10'(FRICTION) : '0;
    // capture uses the clamped position and the speed before friction
    assign sink_ok = in_window(x_clamp, HOLE_X, HOLE_R) && in_window(y_clamp, HOLE_Y, HOLE_R)
                     && speed <= 10'(SINK_SPEED);

    assign rolling = state == ROLL;
    assign sunk    = state == SUNK;

    always_comb begin
        state_n   = state;
        ballx_n   = ballx;
        bally_n   = bally;
        angle_n   = angle;
        power_n   = power;
        strokes_n = strokes;
        speed_n   = speed;
        cos_lat_n = cos_lat;
        sin_lat_n = sin_lat;
        x_neg_n   = x_neg;
        y_neg_n   = y_neg;
        case (state)
            AIM: begin
                if (frame_tick) begin
                    if (btn_shoot) begin
                        state_n = CHARGE;
                        power_n = '0;
                    end else if (btn_left && !btn_right) begin
                        angle_n = angle == 16'd359 ? 16'd0 : angle + 16'd1;
                    end else if (btn_right && !btn_left) begin
                        angle_n = angle == 16'd0 ? 16'd359 : angle - 16'd1;
                    end
                end
            end
            CHARGE: begin
                // release is sampled every cycle; the angle has been stable
                // since before the charge began, so the lookup is current
                if (!btn_shoot) begin
                    if (power == 6'd0) begin
                        state_n = AIM;
                    end else begin
                        speed_n   = 10'(int'(power) * POWER_SCALE);
                        cos_lat_n = cos_abs;
                        sin_lat_n = sin_abs;
                        x_neg_n   = cos_sign;
                        y_neg_n   = sin_sign;
                        strokes_n = strokes == 8'hFF ? strokes : strokes + 8'd1;
                        power_n   = '0;
                        state_n   = ROLL;
                    end
                end else if (frame_tick && power != 6'(MAX_POWER)) begin
                    power_n = power + 6'd1;
                end
            end
            ROLL: begin
                if (frame_tick) begin
                    ballx_n = x_clamp[15:0];
                    bally_n = y_clamp[15:0];
                    x_neg_n = x_neg ^ (x_lo | x_hi);
                    y_neg_n = y_neg ^ (y_lo | y_hi);
                    speed_n = speed_dec;
                    if (sink_ok) begin
                        ballx_n = 16'(HOLE_X << FRAC_BITS);
                        bally_n = 16'(HOLE_Y << FRAC_BITS);
                        speed_n = '0;
                        state_n = SUNK;
                    end else if (speed_dec == 10'd0) begin
                        state_n = AIM;
                    end
                end
            end
            default: begin
                if (btn_shoot && !shoot_q) begin
                    ballx_n   = 16'(START_X << FRAC_BITS);
                    bally_n   = 16'(START_Y << FRAC_BITS);
                    strokes_n = '0;
                    state_n   = AIM;
                end
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= AIM;
            ballx   <= 16'(START_X << FRAC_BITS);
            bally   <= 16'(START_Y << FRAC_BITS);
            angle   <= '0;
            power   <= '0;
            strokes <= '0;
            speed   <= '0;
            cos_lat <= '0;
            sin_lat <= '0;
            x_neg   <= 1'b0;
            y_neg   <= 1'b0;
            shoot_q <= 1'b0;
        end else begin
            state   <= state_n;
            ballx   <= ballx_n;
            bally   <= bally_n;
            angle   <= angle_n;
            power   <= power_n;
            strokes <= strokes_n;
            speed   <= speed_n;
            cos_lat <= cos_lat_n;
            sin_lat <= sin_lat_n;
            x_neg   <= x_neg_n;
            y_neg   <= y_neg_n;
            shoot_q <= btn_shoot;
        end
    end

endmodule

// File: tb/tb_golf_ball_ctrl.sv
// tb_golf_ball_ctrl: directed and randomized checks of golf_ball_ctrl against a behavioural model.
module tb_golf_ball_ctrl;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        frame_tick = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_shoot = 1'b0;
    logic [15:0] ballx, bally, angle;
    logic [5:0]  power;
    logic        rolling, sunk;
    logic [7:0]  strokes;

    int checks = 0;
    int errors = 0;

    golf_ball_ctrl dut (
        .pixel_clk_in(pixel_clk_in),
        .rst_in      (rst_in),
        .frame_tick  (frame_tick),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_shoot   (btn_shoot),
        .ballx       (ballx),
        .bally       (bally),
        .angle       (angle),
        .power       (power),
        .rolling     (rolling),
        .sunk        (sunk),
        .strokes     (strokes)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Behavioural model: plain integers, real trigonometry, +1/-1 directions.
    localparam int M_AIM = 0, M_CHARGE = 1, M_ROLL = 2, M_SUNK = 3;
    localparam real PI = 3.14159265358979;
    int m_x, m_y, m_ang, m_pow, m_str, m_spd, m_ca, m_sa, m_cd, m_sd, m_mode;
    logic m_prev_s;
    logic lip_pending = 1'b0;
    int min_x;

    task automatic m_reset();
        m_x = 160 * 32; m_y = 360 * 32; m_ang = 0; m_pow = 0; m_str = 0;
        m_spd = 0; m_mode = M_AIM; m_prev_s = 1'b0;
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    task automatic m_launch();
        real rad, c, s;
        rad = real'(m_ang) * PI / 180.0;
        c = $cos(rad);
        s = $sin(rad);
        m_spd = m_pow * 4;
        m_ca = $rtoi(256.0 * (c < 0.0 ? -c : c) + 0.5);
        m_sa = $rtoi(256.0 * (s < 0.0 ? -s : s) + 0.5);
        m_cd = c < 0.0 ? -1 : 1;
        m_sd = s < 0.0 ? -1 : 1;
        m_str = m_str < 255 ? m_str + 1 : 255;
        m_pow = 0;
        m_mode = M_ROLL;
    endtask

    task automatic m_roll_step();
        logic near;
        m_x += m_cd * (m_spd * m_ca / 256);
        m_y -= m_sd * (m_spd * m_sa / 256);
        if (m_x < 4 * 32) begin m_x = 4 * 32; m_cd = -m_cd; end
        else if (m_x > 1275 * 32) begin m_x = 1275 * 32; m_cd = -m_cd; end
        if (m_y < 4 * 32) begin m_y = 4 * 32; m_sd = -m_sd; end
        else if (m_y > 715 * 32) begin m_y = 715 * 32; m_sd = -m_sd; end
        near = iabs(m_x / 32 - 1100) <= 4 && iabs(m_y / 32 - 360) <= 4;
        if (near && m_spd <= 96) begin
            m_x = 1100 * 32; m_y = 360 * 32; m_spd = 0; m_mode = M_SUNK;
        end else begin
            lip_pending = near;
            m_spd = m_spd > 1 ? m_spd - 1 : 0;
            if (m_spd == 0) m_mode = M_AIM;
        end
    endtask

    task automatic m_update(input logic l, input logic r, input logic s, input logic t);
        case (m_mode)
            M_AIM: if (t) begin
                if (s) begin m_mode = M_CHARGE; m_pow = 0; end
                else if (l && !r) m_ang = (m_ang + 1) % 360;
                else if (r && !l) m_ang = (m_ang + 359) % 360;
            end
            M_CHARGE: begin
                if (!s) begin
                    if (m_pow == 0) m_mode = M_AIM;
                    else m_launch();
                end else if (t && m_pow < 63) m_pow++;
            end
            M_ROLL: if (t) m_roll_step();
            default: if (s && !m_prev_s) begin
                m_x = 160 * 32; m_y = 360 * 32; m_str = 0; m_mode = M_AIM;
            end
        endcase
        m_prev_s = s;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("ballx", 32'(ballx), m_x);
        chk("bally", 32'(bally), m_y);
        chk("angle", 32'(angle), m_ang);
        chk("power", 32'(power), m_pow);
        chk("strokes", 32'(strokes), m_str);
        chk("rolling", 32'(rolling), 32'(m_mode == M_ROLL));
        chk("sunk", 32'(sunk), 32'(m_mode == M_SUNK));
        if (lip_pending) begin
            chk("lipout_no_sink", 32'(sunk), 0);
            lip_pending = 1'b0;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input logic l, input logic r, input logic s, input logic t);
        btn_left = l; btn_right = r; btn_shoot = s; frame_tick = t;
        m_update(l, r, s, t);
        @(posedge pixel_clk_in);
        #1;
        check_all();
        @(negedge pixel_clk_in);
    endtask

    task automatic tick(input logic l, input logic r, input logic s);
        cyc(l, r, s, 1'b1);
        cyc(l, r, s, 1'b0);
    endtask

    task automatic do_reset();
        btn_left = 0; btn_right = 0; btn_shoot = 0; frame_tick = 0;
        rst_in = 1'b1;
        m_reset();
        #1;
        check_all();
        @(posedge pixel_clk_in);
        #1;
        check_all();
        @(negedge pixel_clk_in);
        rst_in = 1'b0;
    endtask

    task automatic turn_to(input int target);
        for (int i = 0; i < 360 && m_ang != target; i++) begin
            if ((target - m_ang + 360) % 360 <= 180) tick(1, 0, 0);
            else tick(0, 1, 0);
        end
    endtask

    task automatic roll_out();
        int n;
        n = 0;
        while (m_mode == M_ROLL && n < 400) begin
            tick(0, 0, 0);
            if (ballx < min_x) min_x = ballx;
            n++;
        end
        chk("roll_finished", 32'(rolling), 0);
    endtask

    task automatic shot(input int n);
        tick(0, 0, 1);
        repeat (n) tick(0, 0, 1);
        cyc(0, 0, 0, 0);
        roll_out();
    endtask

    initial begin
        @(negedge pixel_clk_in);
        do_reset();
        chk("reset_ballx", 32'(ballx), 5120);
        chk("reset_bally", 32'(bally), 11520);

        tick(0, 1, 0);
        chk("wrap_down", 32'(angle), 359);
        tick(1, 0, 0);
        tick(1, 0, 0);
        chk("wrap_up", 32'(angle), 1);
        tick(1, 1, 0);
        chk("both_buttons", 32'(angle), 1);

        tick(0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("zero_power_strokes", 32'(strokes), 0);
        tick(0, 1, 0);
        chk("zero_power_back_to_aim", 32'(angle), 0);

        tick(0, 0, 1);
        repeat (10) tick(0, 0, 1);
        chk("charge_power", 32'(power), 10);
        cyc(0, 0, 0, 1);
        chk("release_strokes", 32'(strokes), 1);
        chk("release_rolling", 32'(rolling), 1);
        chk("release_tick_no_step", 32'(ballx), 5120);
        tick(0, 0, 0);
        chk("first_step_x", 32'(ballx), 5160);
        chk("first_step_y", 32'(bally), 11520);
        roll_out();
        chk("straight_stop_x", 32'(ballx), 5940);

        turn_to(180);
        min_x = 65535;
        shot(63);
        chk("wall_clamp", min_x, 128);

        do_reset();
        shot(63);
        chk("sink_flag", 32'(sunk), 1);
        chk("sink_x", 32'(ballx), 35200);
        chk("sink_y", 32'(bally), 11520);
        cyc(0, 0, 1, 0);
        chk("retrieve_x", 32'(ballx), 5120);
        chk("retrieve_strokes", 32'(strokes), 0);
        cyc(0, 0, 0, 0);

        shot(40);
        chk("approach1_x", 32'(ballx), 18000);
        shot(40);
        chk("approach2_x", 32'(ballx), 30880);
        shot(63);
        if (m_mode == M_SUNK) begin cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); end

        turn_to(30);
        tick(0, 0, 1);
        repeat (20) tick(0, 0, 1);
        cyc(0, 0, 0, 0);
        repeat (5) tick(0, 0, 0);
        chk("pre_reset_rolling", 32'(rolling), 1);
        do_reset();
        chk("mid_roll_reset_x", 32'(ballx), 5120);
        chk("mid_roll_reset_rolling", 32'(rolling), 0);
        chk("mid_roll_reset_strokes", 32'(strokes), 0);

        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 30)) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            turn_to(int'($urandom_range(0, 359)));
            shot(int'($urandom_range(0, 70)));
            if (m_mode == M_SUNK) begin cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
